// File: rtl/ps2_packet_assembler_if.sv
// Frame input / packet output bundle between the PS/2 receiver, the packet
// assembler and the downstream mouse logic.
interface ps2_packet_assembler_if #(
    parameter int NUM_WORDS = 3,
    parameter int ERR_CNT_W = 8
);
    logic [10:0]            i_frame;
    logic                   i_frame_stb;
    logic [8*NUM_WORDS-1:0] o_packet;
    logic                   o_packet_valid;
    logic                   o_packet_err;
    logic [2:0]             o_err_code;
    logic [ERR_CNT_W-1:0]   o_err_count;
    logic                   o_busy;

    // Receiver side: supplies frames, observes packets and errors.
    modport master (
        output i_frame, i_frame_stb,
        input  o_packet, o_packet_valid, o_packet_err, o_err_code, o_err_count, o_busy
    );

    // Assembler side.
    modport slave (
        input  i_frame, i_frame_stb,
        output o_packet, o_packet_valid, o_packet_err, o_err_code, o_err_count, o_busy
    );
endinterface

// File: rtl/ps2_packet_assembler.sv
// PS/2 packet assembler: validates each 11-bit frame as it arrives (start,
// stop, odd parity), collects NUM_WORDS data bytes into one packet, resyncs on
// the mouse sync bit (byte 0, bit 3) and drops stale partial packets after an
// inter-frame timeout. Reports an error class and a saturating error count.
module ps2_packet_assembler #(
    parameter int NUM_WORDS      = 3,
    parameter bit CHECK_SYNC     = 1'b1,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int ERR_CNT_W      = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    ps2_packet_assembler_if.slave bus
);
    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t                 state_reg, state_next;
    logic [IDX_W-1:0]       index_reg, index_next;
    logic [TMR_W-1:0]       timer_reg, timer_next;
    logic [7:0]             stage_reg [NUM_WORDS];
    logic [8*NUM_WORDS-1:0] packet_reg, packet_next;
    logic                   valid_reg;
    logic                   err_reg, err_next;
    logic [2:0]             code_reg, code_next;
    logic [ERR_CNT_W-1:0]   count_reg;
    logic                   wr_en;
    logic [IDX_W-1:0]       wr_idx;
    logic                   done;

    // Frame decode: data bits, framing, odd parity and mouse sync bit.
    logic [7:0] data;
    logic       framing_ok, parity_ok, good, sync_ok;
    assign data       = bus.i_frame[9:2];
    assign framing_ok = !bus.i_frame[10] && bus.i_frame[0];
    assign parity_ok  = ^bus.i_frame[9:1];
    assign good       = framing_ok && parity_ok;
    assign sync_ok    = !CHECK_SYNC || data[3];

    // State register and packet-position bookkeeping.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
            index_reg <= '0;
            timer_reg <= '0;
        end else begin
            state_reg <= state_next;
            index_reg <= index_next;
            timer_reg <= timer_next;
        end
    end

    // Next-state logic: frame acceptance, discard decisions and error class.
    always_comb begin
        state_next = state_reg;
        index_next = index_reg;
        timer_next = timer_reg;
        wr_en      = 1'b0;
        wr_idx     = index_reg;
        done       = 1'b0;
        err_next   = 1'b0;
        code_next  = code_reg;
        case (state_reg)
            IDLE: begin
                if (bus.i_frame_stb) begin
                    if (good && sync_ok) begin
                        wr_en  = 1'b1;
                        wr_idx = '0;
                        if (NUM_WORDS == 1) begin
                            done = 1'b1;
                        end else begin
                            index_next = IDX_W'(1);
                            timer_next = '0;
                            state_next = COLLECT;
                        end
                    end else if (!good) begin
                        err_next  = 1'b1;
                        code_next = {1'b0, !parity_ok, !framing_ok};
                    end else begin
                        err_next  = 1'b1;
                        code_next = 3'b100;
                    end
                end
            end
            COLLECT: begin
                if (bus.i_frame_stb) begin
                    if (good) begin
                        wr_en      = 1'b1;
                        timer_next = '0;
                        if (index_reg == LAST_IDX) begin
                            done       = 1'b1;
                            index_next = '0;
                            state_next = IDLE;
                        end else begin
                            index_next = index_reg + IDX_W'(1);
                        end
                    end else begin
                        // A bad frame only kills the packet; it never restarts one.
                        err_next   = 1'b1;
                        code_next  = {1'b0, !parity_ok, !framing_ok};
                        index_next = '0;
                        state_next = IDLE;
                    end
                end else if (timer_reg == TMR_LAST) begin
                    err_next   = 1'b1;
                    code_next  = 3'b100;
                    index_next = '0;
                    state_next = IDLE;
                end else begin
                    timer_next = timer_reg + TMR_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                index_next = '0;
            end
        endcase
    end

    // Staging bytes plus the completed-packet view that includes this cycle's byte.
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_stage
        assign packet_next[8*gi +: 8] =
            (wr_en && wr_idx == IDX_W'(gi)) ? data : stage_reg[gi];

        // Partial bytes live here so o_packet only ever shows whole packets.
        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                stage_reg[gi] <= '0;
            end else if (wr_en && wr_idx == IDX_W'(gi)) begin
                stage_reg[gi] <= data;
            end
        end
    end

    // Registered packet, pulse outputs, error code and saturating error count.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            packet_reg <= '0;
            valid_reg  <= 1'b0;
            err_reg    <= 1'b0;
            code_reg   <= '0;
            count_reg  <= '0;
        end else begin
            valid_reg <= done;
            err_reg   <= err_next;
            code_reg  <= code_next;
            if (done) begin
                packet_reg <= packet_next;
            end
            if (err_next && count_reg != '1) begin
                count_reg <= count_reg + ERR_CNT_W'(1);
            end
        end
    end

    assign bus.o_packet       = packet_reg;
    assign bus.o_packet_valid = valid_reg;
    assign bus.o_packet_err   = err_reg;
    assign bus.o_err_code     = code_reg;
    assign bus.o_err_count    = count_reg;
    assign bus.o_busy         = (state_reg == COLLECT);
endmodule

// File: tb/tb_ps2_packet_assembler.sv
// Bench for ps2_packet_assembler: three parameterisations share one frame
// stream; each has a queue-based reference model checked every cycle, plus
// directed checks with fixed expected values for the key scenarios.
module tb_ps2_packet_assembler;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] frame;
    logic        stb;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_inst
        localparam int NW = (gi == 0) ? 3 : (gi == 1) ? 4 : 1;
        localparam int CS = (gi == 2) ? 0 : 1;
        localparam int TO = (gi == 2) ? 2 : 16;
        localparam int EW = (gi == 0) ? 2 : (gi == 1) ? 8 : 3;

        ps2_packet_assembler_if #(.NUM_WORDS(NW), .ERR_CNT_W(EW)) bus ();
        assign bus.i_frame     = frame;
        assign bus.i_frame_stb = stb;

        ps2_packet_assembler #(
            .NUM_WORDS(NW), .CHECK_SYNC(CS != 0), .TIMEOUT_CYCLES(TO), .ERR_CNT_W(EW)
        ) u_dut (
            .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
        );

        logic [7:0]  q[$];
        int          idle_cnt = 0;
        logic [63:0] m_pkt = '0;
        bit          m_valid = 0, m_err = 0, m_busy = 0, m_live = 0;
        logic [2:0]  m_code = '0;
        int          m_cnt = 0;

        // Reference model: bytes queue up until a packet is complete.
        initial begin
            bit         fr, par, e;
            logic [7:0] d;
            logic [2:0] c;
            forever begin
                @(posedge clk);
                m_valid = 0;
                e = 0;
                c = '0;
                if (!rst_n) begin
                    q.delete();
                    idle_cnt = 0;
                    m_pkt = '0;
                    m_code = '0;
                    m_cnt = 0;
                    m_live = 1;
                end else if (stb) begin
                    d   = frame[9:2];
                    fr  = (frame[10] == 1'b0) && (frame[0] == 1'b1);
                    par = ^frame[9:1];
                    if (!(fr && par)) begin
                        e = 1;
                        c = {1'b0, !par, !fr};
                        q.delete();
                    end else if (q.size() == 0 && CS != 0 && !d[3]) begin
                        e = 1;
                        c = 3'b100;
                    end else begin
                        q.push_back(d);
                        idle_cnt = 0;
                        if (q.size() == NW) begin
                            m_pkt = '0;
                            foreach (q[k]) m_pkt[8*k +: 8] = q[k];
                            m_valid = 1;
                            q.delete();
                        end
                    end
                end else if (q.size() > 0) begin
                    idle_cnt++;
                    if (idle_cnt == TO) begin
                        e = 1;
                        c = 3'b100;
                        q.delete();
                    end
                end
                m_err = e;
                if (e) begin
                    m_code = c;
                    if (m_cnt < (1 << EW) - 1) m_cnt++;
                end
                m_busy = (q.size() > 0);
            end
        end

        // Compare every output against the model between clock edges.
        always @(negedge clk) begin
            if (m_live) begin
                check($sformatf("u%0d.packet", gi), 64'(bus.o_packet), m_pkt);
                check($sformatf("u%0d.valid", gi), 64'(bus.o_packet_valid), 64'(m_valid));
                check($sformatf("u%0d.err", gi), 64'(bus.o_packet_err), 64'(m_err));
                check($sformatf("u%0d.code", gi), 64'(bus.o_err_code), 64'(m_code));
                check($sformatf("u%0d.count", gi), 64'(bus.o_err_count), 64'(m_cnt));
                check($sformatf("u%0d.busy", gi), 64'(bus.o_busy), 64'(m_busy));
            end
        end
    end

    task automatic send(input logic [7:0] d, input bit s_bad = 0, input bit p_bad = 0,
                        input bit e_bad = 0);
        frame = {s_bad, d, (~(^d)) ^ p_bad, ~e_bad};
        stb   = 1'b1;
        $display("frame start=%0d data=0x%02h parity=%0d stop=%0d", frame[10], d, frame[1], frame[0]);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        stb = 1'b0;
        repeat (n) begin
            frame = 11'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic do_reset(input bit with_stb);
        stb   = with_stb;
        rst_n = 1'b0;
        $display("reset stb=%0d", with_stb);
        @(negedge clk);
        rst_n = 1'b1;
        stb   = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        int         r;
        int         fl;
        logic [1:0] exp_cnt;
        rst_n = 1'b0;
        stb   = 1'b0;
        frame = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Three good bytes back-to-back.
        send(8'h08); send(8'h05); send(8'hFB);
        check("t1_valid", 64'(g_inst[0].bus.o_packet_valid), 64'd1);
        check("t1_packet", 64'(g_inst[0].bus.o_packet), 64'hFB0508);
        check("t1_count", 64'(g_inst[0].bus.o_err_count), 64'd0);
        idle(2);

        // Parity error on the second byte, then a clean packet.
        send(8'h08); send(8'h05, 0, 1, 0);
        check("t2_err", 64'(g_inst[0].bus.o_packet_err), 64'd1);
        check("t2_code", 64'(g_inst[0].bus.o_err_code), 64'b010);
        check("t2_busy", 64'(g_inst[0].bus.o_busy), 64'd0);
        send(8'h09); send(8'h01); send(8'h02);
        check("t2_packet", 64'(g_inst[0].bus.o_packet), 64'h020109);
        idle(2);

        // Sync failure on byte 0, then a synced packet.
        send(8'h00);
        check("t3_code", 64'(g_inst[0].bus.o_err_code), 64'b100);
        check("t3_busy", 64'(g_inst[0].bus.o_busy), 64'd0);
        send(8'h18); send(8'h10); send(8'h20);
        check("t3_packet", 64'(g_inst[0].bus.o_packet), 64'h201018);
        idle(2);

        // Timeout after 16 idle cycles, then a strobe landing on the threshold.
        send(8'h08); idle(15);
        check("t4_no_err_yet", 64'(g_inst[0].bus.o_packet_err), 64'd0);
        idle(1);
        check("t4_timeout", 64'(g_inst[0].bus.o_packet_err), 64'd1);
        check("t4_code", 64'(g_inst[0].bus.o_err_code), 64'b100);
        send(8'h08); idle(15); send(8'h01);
        check("t4_strobe_wins", 64'(g_inst[0].bus.o_packet_err), 64'd0);
        send(8'h02);
        check("t4_packet", 64'(g_inst[0].bus.o_packet), 64'h020108);
        idle(2);

        // Framing errors saturating a 2-bit counter.
        do_reset(0);
        for (int i = 0; i < 5; i++) begin
            send(8'h08, 1, 0, 0);
            exp_cnt = (i < 3) ? 2'(i + 1) : 2'd3;
            check("t5_count", 64'(g_inst[0].bus.o_err_count), 64'(exp_cnt));
            check("t5_code", 64'(g_inst[0].bus.o_err_code), 64'b001);
        end
        idle(2);

        // Reset in the middle of a 4-byte packet.
        do_reset(0);
        send(8'h08); send(8'h01);
        check("t6_busy_before", 64'(g_inst[1].bus.o_busy), 64'd1);
        do_reset(0);
        check("t6_busy", 64'(g_inst[1].bus.o_busy), 64'd0);
        check("t6_err", 64'(g_inst[1].bus.o_packet_err), 64'd0);
        check("t6_packet", 64'(g_inst[1].bus.o_packet), 64'd0);
        send(8'h08); send(8'h01); send(8'h02); send(8'h03);
        check("t6_packet4", 64'(g_inst[1].bus.o_packet), 64'h03020108);
        idle(2);

        // Randomised traffic: good/bad frames, gaps, long stalls, resets.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                do_reset(1'($urandom_range(0, 1)));
            end else if (r < 55) begin
                d = 8'($urandom);
                if ($urandom_range(0, 3) != 0) d[3] = 1'b1;
                send(d);
            end else if (r < 65) begin
                fl = $urandom_range(1, 7);
                send(8'($urandom), fl[0], fl[1], fl[2]);
            end else if (r < 95) begin
                idle(1);
            end else begin
                idle($urandom_range(10, 20));
            end
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
